// File: rtl/decode_queue_pkg.sv
// Shared decode definitions: opcodes, type indices, branch/load encodings and the
// decoded_t entry that flows from the lanes through the queue.
package definitions;

  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;

  // Bit positions inside the one-hot instr_type vector.
  localparam int DO_REG    = 0;
  localparam int DO_IMM    = 1;
  localparam int DO_JAL    = 2;
  localparam int DO_JALR   = 3;
  localparam int DO_BRANCH = 4;
  localparam int DO_LOAD   = 5;
  localparam int DO_STORE  = 6;
  localparam int DO_LUI    = 7;
  localparam int DO_AUIPC  = 8;
  localparam int NUM_TYPES = 9;

  localparam logic [5:0] EQ_MASK  = 6'b000001;
  localparam logic [5:0] NE_MASK  = 6'b000010;
  localparam logic [5:0] LT_MASK  = 6'b000100;
  localparam logic [5:0] GE_MASK  = 6'b001000;
  localparam logic [5:0] LTU_MASK = 6'b010000;
  localparam logic [5:0] GEU_MASK = 6'b100000;

  localparam logic [2:0] LD_BYTE  = 3'b001;
  localparam logic [2:0] LD_HWORD = 3'b010;
  localparam logic [2:0] LD_WORD  = 3'b100;

  // funct3 bit that marks LBU/LHU.
  localparam int LOAD_UNSIGNED_BIT = 2;

  typedef struct packed {
    logic [31:0]          pc;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           rd;
    logic [31:0]          imm;
    logic [NUM_TYPES-1:0] instr_type;
    logic                 add_or_sub;
    logic [5:0]           branch_type;
    logic [2:0]           load_type;
    logic                 load_unsigned;
    logic                 illegal;
  } decoded_t;

endpackage

// File: rtl/decode_queue_if.sv
// Fetch-side and register-read-side handshake bundle of the decode queue.
interface decode_queue_if #(
  parameter int LANES = 2,
  parameter int DEPTH = 8
);
  import definitions::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_pc;
  logic [LANES-1:0][31:0] in_lines;
  logic [LANES-1:0]      in_mask;
  logic                  out_valid;
  logic                  out_ready;
  decoded_t              out_entry;
  logic                  flush;
  logic [CW-1:0]         count;

  modport master (
    output in_valid, in_pc, in_lines, in_mask, out_ready, flush,
    input  in_ready, out_valid, out_entry, count
  );

  modport slave (
    input  in_valid, in_pc, in_lines, in_mask, out_ready, flush,
    output in_ready, out_valid, out_entry, count
  );

endinterface

// File: rtl/decode_queue_lane.sv
// Combinational RV32I decoder for a single fetch lane: word + pc -> decoded_t.
module decode_lane
  import definitions::*;
(
  input  logic [31:0] line_i,
  input  logic [31:0] pc_i,
  output decoded_t    entry_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;

  assign opcode = line_i[6:0];
  assign funct3 = line_i[14:12];
  assign imm_i  = {{20{line_i[31]}}, line_i[31:20]};
  assign imm_s  = {{20{line_i[31]}}, line_i[31:25], line_i[11:7]};
  assign imm_b  = {{19{line_i[31]}}, line_i[31], line_i[7], line_i[30:25], line_i[11:8], 1'b0};
  assign imm_j  = {{11{line_i[31]}}, line_i[31], line_i[19:12], line_i[20], line_i[30:21], 1'b0};
  assign imm_u  = {line_i[31:12], 12'b0};

  always_comb begin
    // NOTE: the whole struct gets a default first, so no decode path can infer a latch.
    entry_o     = '0;
    entry_o.pc  = pc_i;
    entry_o.rs1 = line_i[19:15];
    entry_o.rs2 = line_i[24:20];
    entry_o.rd  = line_i[11:7];
    case (opcode)
      OP_REG: begin
        entry_o.instr_type[DO_REG] = 1'b1;
        entry_o.add_or_sub         = (line_i[31:25] == 7'h20);
      end
      OP_IMM:   begin entry_o.instr_type[DO_IMM]   = 1'b1; entry_o.imm = imm_i; end
      OP_JAL:   begin entry_o.instr_type[DO_JAL]   = 1'b1; entry_o.imm = imm_j; end
      OP_JALR:  begin entry_o.instr_type[DO_JALR]  = 1'b1; entry_o.imm = imm_i; end
      OP_STORE: begin entry_o.instr_type[DO_STORE] = 1'b1; entry_o.imm = imm_s; end
      OP_LUI:   begin entry_o.instr_type[DO_LUI]   = 1'b1; entry_o.imm = imm_u; end
      OP_AUIPC: begin entry_o.instr_type[DO_AUIPC] = 1'b1; entry_o.imm = imm_u; end
      OP_BRANCH: begin
        entry_o.instr_type[DO_BRANCH] = 1'b1;
        entry_o.imm                   = imm_b;
        case (funct3)
          3'd0:    entry_o.branch_type = EQ_MASK;
          3'd1:    entry_o.branch_type = NE_MASK;
          3'd4:    entry_o.branch_type = LT_MASK;
          3'd5:    entry_o.branch_type = GE_MASK;
          3'd6:    entry_o.branch_type = LTU_MASK;
          3'd7:    entry_o.branch_type = GEU_MASK;
          default: entry_o.illegal     = 1'b1;
        endcase
      end
      OP_LOAD: begin
        entry_o.instr_type[DO_LOAD] = 1'b1;
        entry_o.imm                 = imm_i;
        case (funct3)
          3'd0, 3'd4: begin
            entry_o.load_type     = LD_BYTE;
            entry_o.load_unsigned = funct3[LOAD_UNSIGNED_BIT];
          end
          3'd1, 3'd5: begin
            entry_o.load_type     = LD_HWORD;
            entry_o.load_unsigned = funct3[LOAD_UNSIGNED_BIT];
          end
          3'd2:    entry_o.load_type = LD_WORD;
          default: entry_o.illegal   = 1'b1;
        endcase
      end
      default: entry_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// Multi-lane decode stage: decodes each fetch lane, compacts valid lanes in program
// order into a DEPTH-entry FIFO and drains one entry per cycle to register read.
module decode_queue
  import definitions::*;
#(
  parameter int LANES = 2,
  parameter int DEPTH = 8
) (
  input logic         clock,
  input logic         reset,
  decode_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - LANES);

  decoded_t      lane_dec [LANES];
  decoded_t      mem_q    [DEPTH];
  logic [PW-1:0] lane_off [LANES];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] pushed;
  logic          push, pop;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    decode_lane u_lane (
      .line_i  (bus.in_lines[i]),
      .pc_i    (bus.in_pc + 32'(4 * i)),
      .entry_o (lane_dec[i])
    );
  end

  // Each lane's slot offset is the number of enabled lanes below it.
  always_comb begin
    pushed = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_off[i] = PW'(pushed);
      pushed      = pushed + CW'(bus.in_mask[i]);
    end
  end

  assign bus.in_ready  = !reset && (count_q <= READY_MAX);
  assign bus.out_valid = (count_q != '0);
  assign bus.out_entry = mem_q[rd_ptr_q];
  assign bus.count     = count_q;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(pushed);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + (push ? pushed : '0) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count and pointers alone say which slots are live.
  always_ff @(posedge clock) begin
    if (push && !bus.flush) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.in_mask[i]) mem_q[wr_ptr_q + lane_off[i]] <= lane_dec[i];
      end
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized push/pop/flush traffic.
module tb_decode_queue;
  import definitions::*;

  localparam int LANES = 2;
  localparam int DEPTH = 8;

  logic clock = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   model_on = 1'b0;
  bit   last_accept = 1'b0;
  decoded_t q[$];

  always #5 clock = ~clock;

  decode_queue_if #(.LANES(LANES), .DEPTH(DEPTH)) ifc ();

  decode_queue #(.LANES(LANES), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decoder written from the ISA field rules with plain arithmetic.
  function automatic decoded_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    decoded_t d;
    int f3, v, slot;
    int br_slot [8] = '{0, 1, -1, -1, 2, 3, 4, 5};
    d     = '0;
    d.pc  = pc;
    d.rd  = w[11:7];
    d.rs1 = w[19:15];
    d.rs2 = w[24:20];
    f3    = int'(w[14:12]);
    case (w[6:0])
      7'h33: begin d.instr_type[DO_REG] = 1'b1; d.add_or_sub = (w[31:25] == 7'h20); end
      7'h13: begin d.instr_type[DO_IMM]  = 1'b1; d.imm = 32'($signed(w) >>> 20); end
      7'h67: begin d.instr_type[DO_JALR] = 1'b1; d.imm = 32'($signed(w) >>> 20); end
      7'h37: begin d.instr_type[DO_LUI]   = 1'b1; d.imm = w & 32'hFFFFF000; end
      7'h17: begin d.instr_type[DO_AUIPC] = 1'b1; d.imm = w & 32'hFFFFF000; end
      7'h23: begin
        d.instr_type[DO_STORE] = 1'b1;
        v = (($signed(w) >>> 25) * 32) + int'(w[11:7]);
        d.imm = 32'(v);
      end
      7'h63: begin
        d.instr_type[DO_BRANCH] = 1'b1;
        v = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        d.imm = 32'(v);
        slot = br_slot[f3];
        if (slot < 0) d.illegal = 1'b1;
        else          d.branch_type = 6'(1 << slot);
      end
      7'h6F: begin
        d.instr_type[DO_JAL] = 1'b1;
        v = (w[31] ? -(1 << 20) : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
            + int'(w[30:21]) * 2;
        d.imm = 32'(v);
      end
      7'h03: begin
        d.instr_type[DO_LOAD] = 1'b1;
        d.imm = 32'($signed(w) >>> 20);
        if (f3 == 3 || f3 == 6 || f3 == 7) d.illegal = 1'b1;
        else begin
          d.load_type     = 3'(1 << (f3 % 4));
          d.load_unsigned = (f3 >= 4);
        end
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  task automatic cmp_entry(input decoded_t a, input decoded_t e);
    check("entry.pc", a.pc, e.pc);
    check("entry.illegal", 32'(a.illegal), 32'(e.illegal));
    if (!e.illegal) begin
      check("entry.rs1", 32'(a.rs1), 32'(e.rs1));
      check("entry.rs2", 32'(a.rs2), 32'(e.rs2));
      check("entry.rd", 32'(a.rd), 32'(e.rd));
      check("entry.instr_type", 32'(a.instr_type), 32'(e.instr_type));
      check("entry.add_or_sub", 32'(a.add_or_sub), 32'(e.add_or_sub));
      if (!e.instr_type[DO_REG]) check("entry.imm", a.imm, e.imm);
      if (e.instr_type[DO_BRANCH]) check("entry.branch_type", 32'(a.branch_type), 32'(e.branch_type));
      if (e.instr_type[DO_LOAD]) begin
        check("entry.load_type", 32'(a.load_type), 32'(e.load_type));
        check("entry.load_unsigned", 32'(a.load_unsigned), 32'(e.load_unsigned));
      end
    end
  endtask

  // Reference model: an ordered queue of decoded entries.
  always @(posedge clock) begin
    bit rdy;
    rdy = !reset && ((DEPTH - q.size()) >= LANES);
    last_accept = ifc.in_valid && rdy;
    if (reset) begin
      q.delete();
      model_on = 1'b1;
    end else if (ifc.flush) begin
      q.delete();
    end else begin
      if (q.size() != 0 && ifc.out_ready) void'(q.pop_front());
      if (last_accept) begin
        for (int l = 0; l < LANES; l++)
          if (ifc.in_mask[l]) q.push_back(ref_decode(ifc.in_lines[l], ifc.in_pc + 32'(4 * l)));
      end
    end
  end

  always @(negedge clock) begin
    if (model_on) begin
      check("count", 32'(ifc.count), 32'(q.size()));
      check("count_range", 32'(ifc.count <= DEPTH), 32'd1);
      check("in_ready", 32'(ifc.in_ready), 32'(!reset && ((DEPTH - q.size()) >= LANES)));
      check("out_valid", 32'(ifc.out_valid), 32'(q.size() != 0));
      if (q.size() != 0) cmp_entry(ifc.out_entry, q[0]);
    end
  end

  function automatic logic [31:0] gen_word();
    logic [6:0]  ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
    logic [31:0] w = $urandom;
    int          k = $urandom_range(0, 11);
    if (k < 10) w[6:0] = ops[k];
    if (w[6:0] == 7'h33 && $urandom_range(0, 1) == 1) w[31:25] = 7'h20;
    return w;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    decoded_t m;
    reset         = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.in_pc     = '0;
    ifc.in_lines  = '0;
    ifc.in_mask   = '0;
    ifc.out_ready = 1'b0;
    ifc.flush     = 1'b0;

    // Literal pins on the reference decoder itself.
    m = ref_decode(32'h00500093, 32'h0);
    check("model.addi_imm", m.imm, 32'd5);
    m = ref_decode(32'hFE000EE3, 32'h0);
    check("model.beq_imm", m.imm, 32'hFFFFFFFC);
    check("model.beq_type", 32'(m.branch_type), 32'(EQ_MASK));
    m = ref_decode(32'h008000EF, 32'h0);
    check("model.jal_imm", m.imm, 32'd8);
    m = ref_decode(32'h123450B7, 32'h0);
    check("model.lui_imm", m.imm, 32'h12345000);
    m = ref_decode(32'h00002063, 32'h0);
    check("model.br_f3_2_illegal", 32'(m.illegal), 32'd1);
    m = ref_decode(32'h00003003, 32'h0);
    check("model.ld_f3_3_illegal", 32'(m.illegal), 32'd1);

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("ready_in_reset", 32'(ifc.in_ready), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("ready_after_reset", 32'(ifc.in_ready), 32'd1);
    check("count_after_reset", 32'(ifc.count), 32'd0);
    check("out_valid_after_reset", 32'(ifc.out_valid), 32'd0);

    // Single decode: addi x1,x0,5 at pc 0x100.
    ifc.in_valid = 1'b1; ifc.in_pc = 32'h100; ifc.in_mask = 2'b01; ifc.out_ready = 1'b1;
    ifc.in_lines[0] = 32'h00500093; ifc.in_lines[1] = 32'h0;
    @(negedge clock);
    ifc.in_valid = 1'b0;
    check("addi.out_valid", 32'(ifc.out_valid), 32'd1);
    check("addi.imm", ifc.out_entry.imm, 32'd5);
    check("addi.rd", 32'(ifc.out_entry.rd), 32'd1);
    check("addi.rs1", 32'(ifc.out_entry.rs1), 32'd0);
    check("addi.do_imm", 32'(ifc.out_entry.instr_type[DO_IMM]), 32'd1);
    check("addi.pc", ifc.out_entry.pc, 32'h100);
    check("addi.illegal", 32'(ifc.out_entry.illegal), 32'd0);
    @(negedge clock);

    // Compaction: only lane 1 valid.
    ifc.out_ready = 1'b0; ifc.in_valid = 1'b1; ifc.in_pc = 32'h200; ifc.in_mask = 2'b10;
    ifc.in_lines[0] = 32'h0000007F; ifc.in_lines[1] = 32'h00812283;
    @(negedge clock);
    ifc.in_valid = 1'b0;
    check("lw.count", 32'(ifc.count), 32'd1);
    check("lw.pc", ifc.out_entry.pc, 32'h204);
    check("lw.imm", ifc.out_entry.imm, 32'd8);
    check("lw.rs1", 32'(ifc.out_entry.rs1), 32'd2);
    check("lw.rd", 32'(ifc.out_entry.rd), 32'd5);
    check("lw.load_type", 32'(ifc.out_entry.load_type), 32'(LD_WORD));
    ifc.out_ready = 1'b1;
    @(negedge clock);

    // Back-pressure with sub x3,x1,x2.
    ifc.out_ready = 1'b0; ifc.in_valid = 1'b1; ifc.in_pc = 32'h300; ifc.in_mask = 2'b01;
    ifc.in_lines[0] = 32'h402081B3; ifc.in_lines[1] = 32'h402081B3;
    @(negedge clock);
    ifc.in_mask = 2'b11;
    for (int k = 0; k < 10 && ifc.in_ready; k++) @(negedge clock);
    check("bp.count_full", 32'(ifc.count), 32'd7);
    check("bp.in_ready_low", 32'(ifc.in_ready), 32'd0);
    check("bp.add_or_sub", 32'(ifc.out_entry.add_or_sub), 32'd1);
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
    @(negedge clock);
    check("bp.count_after_pop", 32'(ifc.count), 32'd6);
    check("bp.in_ready_back", 32'(ifc.in_ready), 32'd1);
    for (int k = 0; k < 16 && ifc.count != 0; k++) @(negedge clock);
    check("bp.drained", 32'(ifc.count), 32'd0);

    // Branch encodings and illegal opcode.
    ifc.in_valid = 1'b1; ifc.in_pc = 32'h400; ifc.in_mask = 2'b11;
    ifc.in_lines[0] = 32'hFE000EE3; ifc.in_lines[1] = 32'h0000007F;
    @(negedge clock);
    ifc.in_lines[0] = 32'h00006063; ifc.in_lines[1] = 32'h00007063; ifc.in_pc = 32'h500;
    check("beq.imm", ifc.out_entry.imm, 32'hFFFFFFFC);
    check("beq.branch_type", 32'(ifc.out_entry.branch_type), 32'(EQ_MASK));
    @(negedge clock);
    ifc.in_valid = 1'b0;
    check("op7f.illegal", 32'(ifc.out_entry.illegal), 32'd1);
    check("op7f.pc", ifc.out_entry.pc, 32'h404);
    @(negedge clock);
    check("bltu.branch_type", 32'(ifc.out_entry.branch_type), 32'(LTU_MASK));
    @(negedge clock);
    check("bgeu.branch_type", 32'(ifc.out_entry.branch_type), 32'(GEU_MASK));
    @(negedge clock);
    check("br.drained", 32'(ifc.count), 32'd0);

    // Flush priority over same-cycle push and pop.
    ifc.out_ready = 1'b0; ifc.in_valid = 1'b1; ifc.in_pc = 32'h600; ifc.in_mask = 2'b01;
    ifc.in_lines[0] = 32'h00500093; ifc.in_lines[1] = 32'h402081B3;
    @(negedge clock);
    ifc.in_mask = 2'b11;
    @(negedge clock);
    @(negedge clock);
    ifc.in_valid = 1'b0;
    check("flush.count_before", 32'(ifc.count), 32'd5);
    ifc.flush = 1'b1; ifc.in_valid = 1'b1; ifc.out_ready = 1'b1;
    @(negedge clock);
    ifc.flush = 1'b0; ifc.in_valid = 1'b0;
    check("flush.count", 32'(ifc.count), 32'd0);
    check("flush.out_valid", 32'(ifc.out_valid), 32'd0);
    ifc.out_ready = 1'b0; ifc.in_valid = 1'b1; ifc.in_pc = 32'h700; ifc.in_mask = 2'b01;
    @(negedge clock);
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
    check("post_flush.out_valid", 32'(ifc.out_valid), 32'd1);
    check("post_flush.pc", ifc.out_entry.pc, 32'h700);
    @(negedge clock);

    // Random traffic across pointer wrap; packets held until accepted.
    for (int c = 0; c < 400; c++) begin
      if (!ifc.in_valid || last_accept) begin
        ifc.in_valid = ($urandom_range(0, 3) != 0);
        ifc.in_pc    = 32'($urandom) & ~32'h3;
        ifc.in_mask  = 2'($urandom);
        for (int l = 0; l < LANES; l++) ifc.in_lines[l] = gen_word();
      end
      ifc.out_ready = ($urandom_range(0, 2) != 0);
      ifc.flush     = ($urandom_range(0, 31) == 0);
      @(negedge clock);
    end

    ifc.flush = 1'b0; ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
    for (int k = 0; k < 20 && ifc.count != 0; k++) @(negedge clock);
    check("final.drained", 32'(ifc.count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
